// File: rtl/sr04_pkg.sv
// Shared definitions for the multi-channel HC-SR04 ranging controller.
// Holds the controller state encoding and the echo-to-centimetre scale
// constants (distance = echo_us * K_MUL >> K_SHIFT, about 1/58 cm per us).
package sr04_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TRIG    = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_MEAS    = 3'd3,
    ST_GAP     = 3'd4
  } state_t;

  localparam int unsigned K_MUL   = 1130;
  localparam int unsigned K_SHIFT = 16;

endpackage

// File: rtl/sr04_multi_ctrl_if.sv
// Pin/bus bundle between the board, the ranging controller and the consumer
// logic (display/UART).
//   start, auto_en, ch_en, echo     : requests and raw sensor pins into the controller
//   trigger, distance, valid,
//   timeout_err, busy               : results out of the controller
// master = the side driving requests and echo pins; slave = the controller.
interface sr04_multi_ctrl_if #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DIST_W = 12
);
  logic                     start;
  logic                     auto_en;
  logic [N_CH-1:0]          ch_en;
  logic [N_CH-1:0]          echo;
  logic [N_CH-1:0]          trigger;
  logic [N_CH*DIST_W-1:0]   distance;
  logic [N_CH-1:0]          valid;
  logic [N_CH-1:0]          timeout_err;
  logic                     busy;

  modport master (
    output start, auto_en, ch_en, echo,
    input  trigger, distance, valid, timeout_err, busy
  );

  modport slave (
    input  start, auto_en, ch_en, echo,
    output trigger, distance, valid, timeout_err, busy
  );
endinterface

// File: rtl/sr04_tick_gen.sv
// 1 us timebase: a single-cycle registered tick every CLK_HZ/1_000_000 clocks.
//   clk, reset : system clock, asynchronous active-high reset
//   tick       : one-cycle pulse once per microsecond
module sr04_tick_gen #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int unsigned DIV   = CLK_HZ / 1_000_000;
  localparam int unsigned CNT_W = $clog2(DIV);

  logic [CNT_W-1:0] cnt;

  // Free-running prescaler; tick follows the terminal count by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == CNT_W'(DIV - 1));
      cnt  <= (cnt == CNT_W'(DIV - 1)) ? '0 : cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/sr04_multi_ctrl.sv
// Multi-channel HC-SR04 ranging controller. Scans the enabled sensors
// round-robin with one channel in flight, measures the echo pulse in
// microseconds and converts it to saturated centimetres.
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : slave side of sr04_multi_ctrl_if (start/auto_en/ch_en/echo in;
//                trigger/distance/valid/timeout_err/busy out)
module sr04_multi_ctrl #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned DIST_W     = 12,
  parameter int unsigned TRIG_US    = 10,
  parameter int unsigned TIMEOUT_US = 30000,
  parameter int unsigned GAP_US     = 10000
) (
  input  logic              clk,
  input  logic              reset,
  sr04_multi_ctrl_if.slave  bus
);
  import sr04_pkg::*;

  localparam int unsigned ECHO_W = $clog2(TIMEOUT_US + 1);
  localparam int unsigned PROD_W = ECHO_W + 11;
  localparam int unsigned CMP_W  = (PROD_W > DIST_W) ? PROD_W : DIST_W;
  localparam int unsigned MAX_TG = (TRIG_US > GAP_US) ? TRIG_US : GAP_US;
  localparam int unsigned MAX_US = (MAX_TG > TIMEOUT_US) ? MAX_TG : TIMEOUT_US;
  localparam int unsigned US_W   = $clog2(MAX_US + 1);
  localparam logic [CMP_W-1:0] DIST_MAX = CMP_W'({DIST_W{1'b1}});

  state_t                        state;
  logic                          tick;
  logic [N_CH-1:0]               echo_m, echo_s, echo_d;
  logic [N_CH-1:0]               sel;        // one-hot selected channel
  logic [N_CH-1:0]               scan_mask;
  logic [US_W-1:0]               us_cnt;
  logic [ECHO_W-1:0]             echo_cnt;
  logic [N_CH-1:0]               trig_q, valid_q, err_q;
  logic [N_CH-1:0][DIST_W-1:0]   dist_q;
  logic                          busy_q;

  logic                          echo_cur_c, rise_c;
  logic [N_CH-1:0]               higher_c;
  logic [PROD_W-1:0]             prod_c;
  logic [CMP_W-1:0]              scaled_c;
  logic [DIST_W-1:0]             dist_c;

  sr04_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Isolates the lowest set bit of a mask.
  function automatic logic [N_CH-1:0] lowest(input logic [N_CH-1:0] m);
    return m & (~m + N_CH'(1));
  endfunction

  // Two-flop synchronizer plus one delay stage for rise detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      echo_m <= '0;
      echo_s <= '0;
      echo_d <= '0;
    end else begin
      echo_m <= bus.echo;
      echo_s <= echo_m;
      echo_d <= echo_s;
    end
  end

  assign echo_cur_c = |(echo_s & sel);
  assign rise_c     = |(echo_s & ~echo_d & sel);
  // Enabled channels strictly above the current one.
  assign higher_c   = scan_mask & ~(sel | (sel - N_CH'(1)));

  // Saturating echo-count to centimetre conversion; clamp after the shift.
  assign prod_c   = PROD_W'(echo_cnt) * PROD_W'(K_MUL);
  assign scaled_c = CMP_W'(prod_c >> K_SHIFT);
  assign dist_c   = (scaled_c > DIST_MAX) ? DIST_MAX[DIST_W-1:0] : scaled_c[DIST_W-1:0];

  // Scan sequencer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      sel       <= '0;
      scan_mask <= '0;
      us_cnt    <= '0;
      echo_cnt  <= '0;
      trig_q    <= '0;
      valid_q   <= '0;
      err_q     <= '0;
      dist_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      valid_q <= '0;
      unique case (state)
        ST_IDLE: begin
          if ((bus.start || bus.auto_en) && (bus.ch_en != '0)) begin
            scan_mask <= bus.ch_en;
            sel       <= lowest(bus.ch_en);
            us_cnt    <= '0;
            busy_q    <= 1'b1;
            state     <= ST_TRIG;
          end
        end
        ST_TRIG: begin
          trig_q <= sel;
          if (tick) begin
            if (us_cnt == US_W'(TRIG_US - 1)) begin
              trig_q <= '0;
              us_cnt <= '0;
              state  <= ST_WAIT_HI;
            end else begin
              us_cnt <= us_cnt + US_W'(1);
            end
          end
        end
        ST_WAIT_HI: begin
          if (rise_c) begin
            // The rise cycle already has echo high, so a tick here counts.
            echo_cnt <= tick ? ECHO_W'(1) : '0;
            state    <= ST_MEAS;
          end else if (tick) begin
            if (us_cnt == US_W'(TIMEOUT_US - 1)) begin
              err_q  <= err_q | sel;
              us_cnt <= '0;
              state  <= ST_GAP;
            end else begin
              us_cnt <= us_cnt + US_W'(1);
            end
          end
        end
        ST_MEAS: begin
          if (!echo_cur_c) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
              if (sel[i]) dist_q[i] <= dist_c;
            end
            valid_q <= sel;
            err_q   <= err_q & ~sel;
            us_cnt  <= '0;
            state   <= ST_GAP;
          end else if (tick) begin
            if (echo_cnt == ECHO_W'(TIMEOUT_US - 1)) begin
              err_q  <= err_q | sel;
              us_cnt <= '0;
              state  <= ST_GAP;
            end else begin
              echo_cnt <= echo_cnt + ECHO_W'(1);
            end
          end
        end
        ST_GAP: begin
          if (tick) begin
            if (us_cnt == US_W'(GAP_US - 1)) begin
              us_cnt <= '0;
              if (higher_c != '0) begin
                sel   <= lowest(higher_c);
                state <= ST_TRIG;
              end else if (bus.auto_en && (bus.ch_en != '0)) begin
                scan_mask <= bus.ch_en;
                sel       <= lowest(bus.ch_en);
                state     <= ST_TRIG;
              end else begin
                busy_q <= 1'b0;
                state  <= ST_IDLE;
              end
            end else begin
              us_cnt <= us_cnt + US_W'(1);
            end
          end
        end
        default: begin
          trig_q <= '0;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.trigger     = trig_q;
  assign bus.distance    = dist_q;
  assign bus.valid       = valid_q;
  assign bus.timeout_err = err_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_sr04_multi_ctrl.sv
// Directed bench for sr04_multi_ctrl: a vector table of single-channel scans
// plus hand-written multi-channel, auto-repeat and reset sequences.
module tb_sr04_multi_ctrl;
  localparam int unsigned N_CH       = 4;
  localparam int unsigned CLK_HZ     = 2_000_000;   // 2 clocks per us
  localparam int unsigned DIST_W     = 5;
  localparam int unsigned TRIG_US    = 10;
  localparam int unsigned TIMEOUT_US = 2000;
  localparam int unsigned GAP_US     = 20;
  localparam int          CPU        = 2;           // clocks per us

  logic clk;
  logic reset;

  sr04_multi_ctrl_if #(.N_CH(N_CH), .DIST_W(DIST_W)) bus ();

  sr04_multi_ctrl #(
    .N_CH(N_CH), .CLK_HZ(CLK_HZ), .DIST_W(DIST_W), .TRIG_US(TRIG_US),
    .TIMEOUT_US(TIMEOUT_US), .GAP_US(GAP_US)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int vcnt     = 0;   // total valid pulses seen
  int trig2    = 0;   // cycles with trigger[2] high
  int multihot = 0;   // cycles with more than one trigger high

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    vcnt     <= vcnt + $countones(bus.valid);
    trig2    <= trig2 + int'(bus.trigger[2]);
    multihot <= multihot + int'($countones(bus.trigger) > 1);
  end

  int exp_dist [N_CH];
  logic [N_CH-1:0] exp_err;

  typedef struct {
    int ch;
    int echo_us;     // 0 = sensor never answers
    int exp_d;
    bit exp_e;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int dist_of(input int ch);
    logic [N_CH*DIST_W-1:0] d;
    d = bus.distance;
    return int'(d[ch*DIST_W +: DIST_W]);
  endfunction

  task automatic pulse_start();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  task automatic wait_busy_low(input string name, input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin @(negedge clk); n++; end
    chk(name, int'(bus.busy), 0);
  endtask

  task automatic compare_model(input string tag);
    for (int i = 0; i < N_CH; i++)
      chk($sformatf("%s_dist%0d", tag, i), dist_of(i), exp_dist[i]);
    chk($sformatf("%s_err", tag), int'(bus.timeout_err), int'(exp_err));
  endtask

  // One single-channel scan driven from a table record.
  task automatic run_vec(input vec_t v, input int idx);
    int n, first, v0;
    string tag;
    tag = $sformatf("v%0d", idx);
    v0  = vcnt;
    bus.ch_en = N_CH'(1 << v.ch);
    pulse_start();
    n = 0;
    while (!bus.trigger[v.ch] && n < 100) begin @(negedge clk); n++; end
    chk({tag, "_trig_rise"}, int'(bus.trigger[v.ch]), 1);
    n = 0;
    while (bus.trigger[v.ch] && n < 100) begin @(negedge clk); n++; end
    chk({tag, "_trig_width_ok"}, int'(n >= (TRIG_US - 1) * CPU && n <= (TRIG_US + 1) * CPU), 1);
    if (v.echo_us > 0) begin
      repeat (100) @(negedge clk);
      bus.echo[v.ch] = 1'b1;
      repeat (v.echo_us * CPU) @(negedge clk);
      bus.echo[v.ch] = 1'b0;
      first = 0;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (bus.valid[v.ch] && first == 0) first = k;
      end
      chk({tag, "_valid_latency"}, first, 3);
    end else begin
      n = 0;
      while (!bus.timeout_err[v.ch] && n < 4200) begin @(negedge clk); n++; end
      chk({tag, "_timeout_time_ok"},
          int'(n >= (TIMEOUT_US - 5) * CPU && n <= (TIMEOUT_US + 5) * CPU), 1);
    end
    wait_busy_low({tag, "_busy_fall"}, 6000);
    chk({tag, "_valid_count"}, vcnt - v0, (v.echo_us > 0) ? 1 : 0);
    exp_dist[v.ch] = v.exp_d;
    exp_err[v.ch]  = v.exp_e;
    compare_model(tag);
  endtask

  vec_t vecs [8];

  initial begin
    int n, c, prev_t, last_fall, v0, tr0;
    int order [3];

    // 580us -> 10, 1160us -> 20, 1900us -> 32 clamped to 31, 1797us -> 30
    // (one below the clamp), 58us -> 1.
    vecs[0] = '{ch: 0, echo_us: 580,  exp_d: 10, exp_e: 1'b0};
    vecs[1] = '{ch: 0, echo_us: 1160, exp_d: 20, exp_e: 1'b0};
    vecs[2] = '{ch: 0, echo_us: 0,    exp_d: 20, exp_e: 1'b1};
    vecs[3] = '{ch: 0, echo_us: 580,  exp_d: 10, exp_e: 1'b0};
    vecs[4] = '{ch: 1, echo_us: 1900, exp_d: 31, exp_e: 1'b0};
    vecs[5] = '{ch: 2, echo_us: 1797, exp_d: 30, exp_e: 1'b0};
    vecs[6] = '{ch: 3, echo_us: 58,   exp_d: 1,  exp_e: 1'b0};
    vecs[7] = '{ch: 1, echo_us: 58,   exp_d: 1,  exp_e: 1'b0};

    order = '{0, 1, 3};
    for (int i = 0; i < N_CH; i++) exp_dist[i] = 0;
    exp_err = '0;

    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.auto_en = 1'b0;
    bus.ch_en   = '0;
    bus.echo    = '0;
    repeat (3) @(negedge clk);
    chk("rst_trigger", int'(bus.trigger), 0);
    chk("rst_valid", int'(bus.valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    compare_model("rst");
    reset = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Multi-channel scan 1011: order 0,1,3 with each answering 100us (-> 1cm).
    bus.ch_en = 4'b1011;
    tr0 = trig2;
    pulse_start();
    chk("multi_busy_rise", int'(bus.busy), 1);
    prev_t = 0;
    last_fall = 0;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (bus.trigger == '0 && n < 3000) begin @(negedge clk); n++; end
      c = -1;
      for (int i = 0; i < N_CH; i++) if (bus.trigger[i]) c = i;
      chk($sformatf("multi_order%0d", k), c, order[k]);
      if (k > 0) chk($sformatf("multi_spacing%0d_ok", k), int'(cyc - prev_t >= GAP_US * CPU), 1);
      prev_t = cyc;
      if (c < 0) c = 0;
      n = 0;
      while (bus.trigger != '0 && n < 100) begin @(negedge clk); n++; end
      repeat (40) @(negedge clk);
      bus.echo[c] = 1'b1;
      repeat (100 * CPU) @(negedge clk);
      bus.echo[c] = 1'b0;
      last_fall = cyc;
      exp_dist[c] = 1;
    end
    wait_busy_low("multi_busy_fall", 3000);
    chk("multi_busy_after_gap", int'(cyc - last_fall >= GAP_US * CPU), 1);
    chk("multi_trig2_never", trig2 - tr0, 0);
    compare_model("multi");

    // Auto-repeat: two scans of ch0 without start, then auto_en dropped.
    bus.ch_en   = 4'b0001;
    v0          = vcnt;
    bus.auto_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (!bus.trigger[0] && n < 2000) begin @(negedge clk); n++; end
      chk($sformatf("auto_trig%0d", k), int'(bus.trigger[0]), 1);
      if (k == 1) bus.auto_en = 1'b0;
      n = 0;
      while (bus.trigger[0] && n < 100) begin @(negedge clk); n++; end
      repeat (40) @(negedge clk);
      bus.echo[0] = 1'b1;
      repeat (58 * CPU) @(negedge clk);
      bus.echo[0] = 1'b0;
    end
    wait_busy_low("auto_busy_fall", 3000);
    chk("auto_valid_count", vcnt - v0, 2);
    exp_dist[0] = 1;
    compare_model("auto");

    // Reset mid-MEAS clears everything at once.
    bus.ch_en = 4'b0001;
    pulse_start();
    n = 0;
    while (!bus.trigger[0] && n < 100) begin @(negedge clk); n++; end
    while (bus.trigger[0] && n < 200) begin @(negedge clk); n++; end
    repeat (40) @(negedge clk);
    bus.echo[0] = 1'b1;
    repeat (100) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_meas_busy", int'(bus.busy), 0);
    chk("rst_meas_valid", int'(bus.valid), 0);
    chk("rst_meas_trigger", int'(bus.trigger), 0);
    for (int i = 0; i < N_CH; i++) exp_dist[i] = 0;
    exp_err = '0;
    compare_model("rst_meas");
    bus.echo[0] = 1'b0;
    @(negedge clk) reset = 1'b0;
    repeat (4) @(negedge clk);

    // Reset while the trigger is high drops it without a clock edge.
    pulse_start();
    n = 0;
    while (!bus.trigger[0] && n < 100) begin @(negedge clk); n++; end
    chk("rst_trig_high_before", int'(bus.trigger[0]), 1);
    #2 reset = 1'b1;
    #1 chk("rst_trig_async_drop", int'(bus.trigger), 0);
    @(negedge clk) reset = 1'b0;
    repeat (4) @(negedge clk);

    // Clean scan after reset.
    run_vec('{ch: 0, echo_us: 580, exp_d: 10, exp_e: 1'b0}, 8);

    // Empty enable mask: request ignored.
    bus.ch_en = '0;
    pulse_start();
    repeat (10) @(negedge clk);
    chk("empty_mask_busy", int'(bus.busy), 0);
    chk("empty_mask_trigger", int'(bus.trigger), 0);

    chk("trigger_onehot", multihot, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sr04_multi_ctrl.md
# sr04_multi_ctrl

Parametrised multi-channel HC-SR04 ultrasonic ranging controller. It scans up to `N_CH` sensors round-robin, one channel in flight at a time, to avoid acoustic crosstalk. Each scan is started by a single pulse or repeated automatically. Each channel gets an echo timeout, saturating distance arithmetic and per-channel valid/error flags. It sits between the board pins and the display/UART logic and generates its own 1 µs timebase.

## Interface
Parameters:
- `N_CH`, 4: number of sensor channels (1..8).
- `CLK_HZ`, 100_000_000: clk frequency; `CLK_HZ/1_000_000` must be an integer ≥ 2.
- `DIST_W`, 12: distance width per channel, in cm.
- `TRIG_US`, 10: trigger pulse width in µs.
- `TIMEOUT_US`, 30000: maximum wait for echo rise, and maximum echo high time, in µs.
- `GAP_US`, 10000: quiet time after each channel before the next trigger, in µs.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle scan request.
- `auto_en` in 1: level; when high, scans repeat back-to-back.
- `ch_en` in N_CH: channel enable mask.
- `echo` in N_CH: raw, asynchronous sensor echo pins.
- `trigger` out N_CH: sensor trigger pins.
- `distance` out N_CH*DIST_W: channel i occupies bits `[i*DIST_W +: DIST_W]`.
- `valid` out N_CH: one-cycle pulse when channel i's distance is updated.
- `timeout_err` out N_CH: sticky; set on timeout of channel i, cleared when channel i next completes successfully.
- `busy` out 1: high from scan start until return to IDLE.

## Operation
- Reset: all outputs are 0, the FSM is in IDLE and the prescaler is cleared.
- Tick: an internal 1 µs single-cycle tick. All µs counters advance only on ticks.
- Echo input: every bit passes through a 2-flop synchronizer, giving `echo_s`.
- IDLE:
  - On `start` or `auto_en`, with `ch_en != 0`, latch `ch_en` into `scan_mask`, select the lowest set bit and go to TRIG.
  - If `ch_en == 0`, the request is ignored.
  - `start` while busy is ignored.
- TRIG: drive `trigger[ch]` high for exactly `TRIG_US` ticks, then drop it, clear the µs counter and go to WAIT_HI.
- WAIT_HI:
  - Wait for a 0→1 transition of `echo_s[ch]`. An echo that is already high must fall first.
  - On the rise, clear the counter and go to MEAS.
  - If the counter reaches `TIMEOUT_US`, set `timeout_err[ch]` and go to GAP. `distance` is unchanged and there is no `valid`.
- MEAS:
  - Increment `echo_cnt` on each tick while `echo_s[ch]` is 1.
  - In the first clk cycle with `echo_s[ch] == 0`, register `distance[ch] = min((echo_cnt*1130)>>16, 2^DIST_W-1)`, pulse `valid[ch]`, clear `timeout_err[ch]` and go to GAP.
  - If `echo_cnt` reaches `TIMEOUT_US`, set `timeout_err[ch]` and go to GAP.
- GAP: wait `GAP_US` ticks. Then:
  - If a higher enabled bit remains in `scan_mask`, select it and go to TRIG.
  - Else, if `auto_en`, re-latch `ch_en` and start a new scan (IDLE rules apply).
  - Else go to IDLE.
- Arithmetic:
  - `echo_cnt` width is `$clog2(TIMEOUT_US+1)`.
  - The product is computed at `$clog2(TIMEOUT_US+1)+11` bits, so there is no intermediate overflow.
  - The clamp is applied after the shift.
- Only the selected channel's `trigger` can be high. All others are held at 0.
- Reset mid-operation: `trigger` drops immediately (asynchronously), and all distance and flag state is cleared.

## Timing
- `valid[ch]` and the new distance appear on the 3rd clk edge after the echo pin falls: 2 synchronizer edges plus 1 register edge.
- The trigger rises 1 clk after the TRIG entry edge and lasts `TRIG_US` µs ±1 tick.
- `busy` rises on the clk edge after an accepted `start`. It falls when entering IDLE.
- Distance resolution is 1 µs counts, giving about 58 µs/cm (1130/65536 ≈ 1/58).

## Structure
- Package `sr04_pkg` holds:
  - the FSM state encoding (IDLE, TRIG, WAIT_HI, MEAS, GAP);
  - constants `K_MUL = 1130` and `K_SHIFT = 16`.
- Sub-module `sr04_tick_gen`: a parametrised prescaler producing the 1 µs tick from `CLK_HZ`.
- Synchronizers, edge detection, the channel selector and the FSM live in the top module.

## Test plan
- N_CH=1, start, echo high 580 µs after trigger → distance=10, one `valid` pulse, `timeout_err`=0.
- Same channel, echo 1160 µs → distance=20. A 10 µs trigger pulse is measured on the pin.
- `ch_en`=4'b1011, start → triggers fire in order ch0, ch1, ch3 with ≥ `GAP_US` spacing. `trigger[2]` is never high. `busy` falls after ch3's GAP.
- Echo never rises → `timeout_err[0]` set 30000 µs after trigger fall, distance unchanged. A subsequent good echo clears it.
- DIST_W=8, echo 29000 µs → distance=255 (saturated).
- Reset asserted mid-MEAS → `trigger`, `valid`, `busy` and `distance` are 0 at once. `start` after release runs a clean scan; `start` with `ch_en`=0 leaves `busy`=0.
